imem_loader: RTL

- Boot-time writer for the 1024-word instruction memory that the fetch stage reads at word index pc>>2.
- Accepts a byte stream from a host link (valid/ready), assembles bytes into 32-bit instructions MSB-first, and writes them to consecutive word addresses from 0.
- Verifies an XOR checksum, then releases the processor from hold.
- Sits between the host/UART byte receiver and the instruction memory write port; the CPU stays held until a good image is loaded.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream and instruction-memory write bundle for imem_loader
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    // Host side: drives the byte stream, observes the memory write port
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    // Loader side: consumes the byte stream, drives the memory write port
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader with XOR checksum and CPU hold
module imem_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic         cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CKSUM,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal word count; 17 bits so a 16-bit length can be compared against it
    localparam logic [16:0] CAPACITY = 17'(2**ADDR_WIDTH);

    state_t                state_q,     state_d;
    logic [7:0]            len_hi_q,    len_hi_d;
    logic [15:0]           len_q,       len_d;
    // One bit wider than the address so a full-capacity image never wraps to 0
    logic [ADDR_WIDTH:0]   word_cnt_q,  word_cnt_d;
    logic [1:0]            byte_cnt_q,  byte_cnt_d;
    logic [7:0]            acc_q,       acc_d;
    logic [31:0]           asm_q,       asm_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic [16:0] len_full;
    logic [31:0] word_next;

    assign bus.in_ready  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                           (state_q == S_DATA)   || (state_q == S_CKSUM);
    assign accept        = bus.in_ready && bus.in_valid;
    assign len_full      = {1'b0, len_hi_q, bus.in_data};
    assign word_next     = {asm_q[23:0], bus.in_data};

    assign busy          = bus.in_ready;
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERR);
    assign cpu_hold      = (state_q != S_DONE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Next-state, stream parsing, word assembly and write-strobe generation
    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        word_cnt_d  = word_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        acc_d       = acc_q;
        asm_d       = asm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_HI;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    acc_d      = '0;
                    asm_d      = '0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = bus.in_data;
                    acc_d    = acc_q ^ bus.in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_full[15:0];
                    acc_d = acc_q ^ bus.in_data;
                    if (len_full > CAPACITY) begin
                        state_d = S_ERR;
                    end else if (len_full == 17'd0) begin
                        state_d = S_CKSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    acc_d      = acc_q ^ bus.in_data;
                    asm_d      = word_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = word_next;
                        word_cnt_d  = word_cnt_q + 1'b1;
                        if (16'(word_cnt_q) + 16'd1 == len_q) begin
                            state_d = S_CKSUM;
                        end
                    end
                end
            end
            S_CKSUM: begin
                if (accept) begin
                    state_d = (bus.in_data == acc_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; async reset aborts any session in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_hi_q    <= '0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            acc_q       <= '0;
            asm_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            len_q       <= len_d;
            word_cnt_q  <= word_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            acc_q       <= acc_d;
            asm_q       <= asm_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule
